msx_bus_initiator: RTL and testbench
====================================

MSX_BUS_INITIATOR -- requirements
Module: msx_bus_initiator

Interface
REQ-001 SHALL have parameter T_DIV, default 6, meaning the number of clk cycles per Z80 T-state (legal range 2..15).
REQ-002 SHALL have parameter CART_SLOT, default 2'd1, meaning the primary slot number that asserts sltsl_n.
REQ-003 SHALL have parameter WAIT_MAX, default 255, meaning the maximum number of consecutive TW states before abort.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a bus-cycle request is present.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the request is accepted this clk.
REQ-008 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_io, input, 1 bit: 1 = I/O cycle, 0 = memory cycle.
REQ-010 SHALL have port cmd_m1, input, 1 bit: opcode fetch; valid only with a memory read.
REQ-011 SHALL have ports cmd_addr, input, 16 bits, and cmd_wdata, input, 8 bits: request address and write data.
REQ-012 SHALL have ports rsp_valid, output, 1 bit (single-clk pulse at cycle end), rsp_rdata, output, 8 bits, and rsp_err, output, 1 bit (wait timeout).
REQ-013 SHALL have ports addr, output, 16 bits, and cdout, output, 8 bits: bus address and data toward the cartridge.
REQ-014 SHALL have port cdin, input, 8 bits: cartridge read data.
REQ-015 SHALL have port busreq, input, 1 bit: cartridge is driving data; captured into rsp_rdata only when busreq=1, otherwise rsp_rdata=8'hFF.
REQ-016 SHALL have ports merq_n, iorq_n, rd_n, wr_n, m1_n and sltsl_n, output, 1 bit each, all active-low bus strobes.
REQ-017 SHALL have port wait_n, input, 1 bit: active-low wait request.
REQ-018 SHALL have port slot_reg, output, 8 bits: primary slot register (port A8h image).

Function
REQ-019 SHALL implement states IDLE, T1, T2, TW, T3 and DONE, with every T-state lasting exactly T_DIV clks, counted by a prescaler that is reset on entry to each state.
REQ-020 SHALL assert cmd_ready only in IDLE; on cmd_valid&cmd_ready it SHALL latch all cmd_* fields and enter T1 on the next clk.
REQ-021 SHALL behave as follows in T1: addr=latched address; cdout=wdata for writes; m1_n=0 for M1 cycles; all other strobes high.
REQ-022 SHALL, in T2, assert merq_n (memory) or iorq_n (I/O) together with rd_n or wr_n; m1_n stays low for M1 cycles.
REQ-023 SHALL, in T2, assert sltsl_n=0 only for memory cycles where slot_reg[2*addr[15:14]+1 : 2*addr[15:14]] == CART_SLOT.
REQ-024 SHALL, for I/O cycles, always insert exactly one automatic TW after T2 before any wait_n sampling.
REQ-025 SHALL sample wait_n on the last clk of T2 or TW: 0 leads to TW and 1 leads to T3; strobes are held through TW and T3.
REQ-026 SHALL capture rsp_rdata on the last clk of T3 for reads, applying the busreq rule of REQ-015; the captured value is held until the next read.
REQ-027 SHALL, after T3, deassert all strobes and sltsl_n in DONE, pulse rsp_valid for 1 clk, and return to IDLE on the next clk; addr and cdout hold their last values.
REQ-028 SHALL update slot_reg with wdata in DONE when an I/O write has addr[7:0]=8'hA8; the bus cycle is still issued.
REQ-029 SHALL update slot_reg only after DONE, so the next cycle's decode uses the new value.
REQ-030 SHALL, when WAIT_MAX consecutive TW states (excluding the automatic I/O TW) elapse with wait_n=0, go to DONE with rsp_err=1 and rsp_rdata=8'hFF; in all other cases rsp_err=0.
REQ-031 SHALL ignore cmd_valid outside IDLE; back-to-back commands SHALL have at least 1 idle clk (DONE) between cycles.
REQ-032 SHALL give a zero-wait memory cycle a total duration of 3*T_DIV+1 clks from T1 entry to rsp_valid, and an I/O cycle 4*T_DIV+1.

Reset
REQ-033 SHALL, while reset_n=0, force state IDLE, all strobes, m1_n and sltsl_n to 1, addr=16'h0000, cdout=8'h00, slot_reg=8'h00, rsp_valid=0, rsp_err=0, rsp_rdata=8'hFF and cmd_ready=0.
REQ-034 SHALL assert cmd_ready on the first clk after release; reset asserted mid-cycle SHALL immediately release all strobes with no rsp_valid.

Verification
REQ-035 SHALL pass this directed scenario: memory read 0x4000, slot_reg=0x04, wait_n=1, busreq=1, cdin=0x5A -> sltsl_n low in T2/T3, rsp_rdata=0x5A, rsp_valid at 3*T_DIV+1 clks.
REQ-036 SHALL pass this directed scenario: memory write 0x5000 data 0x03 -> merq_n and wr_n low in T2..T3, cdout=0x03 from T1, rd_n stays high throughout.
REQ-037 SHALL pass this directed scenario: I/O write 0xA8 data 0x50, then memory read 0x8000 -> slot_reg=0x50 and sltsl_n asserted on the second cycle (page 2 maps to slot 1).
REQ-038 SHALL pass this directed scenario: I/O read 0x8E with wait_n=1 -> iorq_n and rd_n low, one automatic TW, rsp_valid at 4*T_DIV+1 clks.
REQ-039 SHALL pass this directed scenario: memory read with wait_n held 0 for 3 TW states -> cycle extends by 3*T_DIV clks and rsp_err=0; wait_n held 0 permanently -> rsp_err=1 after WAIT_MAX TW states.
REQ-040 SHALL pass this directed scenario: reset_n pulsed low during TW -> strobes high within the same clk, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/msx_bus_initiator.sv
// Z80-style MSX cartridge bus initiator: turns single requests into T1/T2/TW/T3 bus cycles
// with wait-state handling, primary slot decode and a port-A8h slot register image.
module msx_bus_initiator #(
  parameter int unsigned T_DIV     = 6,
  parameter logic [1:0]  CART_SLOT = 2'd1,
  parameter int unsigned WAIT_MAX  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic        cmd_m1,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr,
  output logic [7:0]  cdout,
  input  logic [7:0]  cdin,
  input  logic        busreq,
  output logic        merq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m1_n,
  output logic        sltsl_n,
  input  logic        wait_n,
  output logic [7:0]  slot_reg
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              auto_q, auto_d;
  logic              wr_q, wr_d, io_q, io_d, m1_q, m1_d;
  logic [15:0]       adr_q, adr_d;
  logic [7:0]        wdat_q, wdat_d;

  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        cdout_q, cdout_d;
  logic              merq_q, merq_d, iorq_q, iorq_d, rdn_q, rdn_d, wrn_q, wrn_d;
  logic              m1n_q, m1n_d, sltsl_q, sltsl_d;
  logic [7:0]        slot_q, slot_d;

  logic              last_c, busy_c, strb_c, slot_hit_c;

  // Sequencer: T-state prescaler, wait counting and command latching
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    auto_d  = auto_q;
    wr_d    = wr_q;
    io_d    = io_q;
    m1_d    = m1_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    slot_d  = slot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    last_c  = (cnt_q == CNT_W'(T_DIV - 1));
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          wr_d    = cmd_write;
          io_d    = cmd_io;
          m1_d    = cmd_m1;
          adr_d   = cmd_addr;
          wdat_d  = cmd_wdata;
          wcnt_d  = '0;
          auto_d  = 1'b0;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (last_c) state_d = S_T2;
      end
      S_T2: begin
        if (last_c) begin
          if (io_q) begin
            state_d = S_TW;
            auto_d  = 1'b1;
          end else if (!wait_n) begin
            state_d = S_TW;
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end else begin
            state_d = S_T3;
          end
        end
      end
      S_TW: begin
        if (last_c) begin
          auto_d = 1'b0;
          if (wait_n) begin
            state_d = S_T3;
          end else if (!auto_q && (wcnt_q == WCNT_W'(WAIT_MAX))) begin
            // Wait timeout: end the cycle without a T3
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = 8'hFF;
          end else begin
            state_d = S_TW;
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end
        end
      end
      S_T3: begin
        if (last_c) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!wr_q) rdata_d = busreq ? cdin : 8'hFF;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (io_q && wr_q && (adr_q[7:0] == 8'hA8)) slot_d = wdat_q;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (last_c || (state_q == S_IDLE) || (state_q == S_DONE)) ? '0 : cnt_q + CNT_W'(1);
  end

  // Bus outputs decoded from the next state so they are registered yet aligned to it
  always_comb begin
    busy_c     = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
    strb_c     = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
    slot_hit_c = (slot_q[{adr_d[15:14], 1'b0} +: 2] == CART_SLOT);
    ready_d    = (state_d == S_IDLE);
    valid_d    = (state_d == S_DONE);
    addr_d     = busy_c ? adr_d : addr_q;
    cdout_d    = (busy_c && wr_d) ? wdat_d : cdout_q;
    merq_d     = !(strb_c && !io_d);
    iorq_d     = !(strb_c && io_d);
    rdn_d      = !(strb_c && !wr_d);
    wrn_d      = !(strb_c && wr_d);
    m1n_d      = !(busy_c && m1_d && !io_d && !wr_d);
    sltsl_d    = !(strb_c && !io_d && slot_hit_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      auto_q  <= 1'b0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      m1_q    <= 1'b0;
      adr_q   <= 16'h0000;
      wdat_q  <= 8'h00;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'hFF;
      addr_q  <= 16'h0000;
      cdout_q <= 8'h00;
      merq_q  <= 1'b1;
      iorq_q  <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      m1n_q   <= 1'b1;
      sltsl_q <= 1'b1;
      slot_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      auto_q  <= auto_d;
      wr_q    <= wr_d;
      io_q    <= io_d;
      m1_q    <= m1_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      cdout_q <= cdout_d;
      merq_q  <= merq_d;
      iorq_q  <= iorq_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      m1n_q   <= m1n_d;
      sltsl_q <= sltsl_d;
      slot_q  <= slot_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign addr      = addr_q;
  assign cdout     = cdout_q;
  assign merq_n    = merq_q;
  assign iorq_n    = iorq_q;
  assign rd_n      = rdn_q;
  assign wr_n      = wrn_q;
  assign m1_n      = m1n_q;
  assign sltsl_n   = sltsl_q;
  assign slot_reg  = slot_q;

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Bench for msx_bus_initiator: table of bus cycles with a response scoreboard,
// plus reset and mid-cycle reset sequences.
module tb_msx_bus_initiator;

  localparam int unsigned TD = 6;
  localparam logic [1:0]  CS = 2'd1;
  localparam int unsigned WM = 255;
  localparam int unsigned BUDGET = (WM + 10) * TD + 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cmd_valid, cmd_ready, cmd_write, cmd_io, cmd_m1;
  logic [15:0] cmd_addr, addr;
  logic [7:0]  cmd_wdata, rsp_rdata, cdout, cdin, slot_reg;
  logic        rsp_valid, rsp_err, busreq, wait_n;
  logic        merq_n, iorq_n, rd_n, wr_n, m1_n, sltsl_n;

  msx_bus_initiator #(.T_DIV(TD), .CART_SLOT(CS), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_io(cmd_io), .cmd_m1(cmd_m1), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .cdout(cdout), .cdin(cdin), .busreq(busreq),
    .merq_n(merq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .sltsl_n(sltsl_n), .wait_n(wait_n), .slot_reg(slot_reg)
  );

  typedef struct {
    logic        wr, io, m1;
    logic [15:0] a;
    logic [7:0]  wd, cdin;
    logic        br;
    int unsigned nw;     // wait_n=0 sample points after T2 (or after the auto I/O TW)
    logic [7:0]  erd;
    logic        eerr, esl;
    int unsigned elat;   // clks from T1 entry to rsp_valid, T1 first clk = 1
    logic [7:0]  eslot;
  } vec_t;

  typedef struct {
    logic [7:0]  rd;
    logic        err, sl;
    int unsigned lat;
  } exp_t;

  vec_t vt[13];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    exp_t e;
    int unsigned s0, lat;
    logic done, s_mr, s_io, s_rd, s_wr, s_m1, s_sl;
    int g;
    e.rd = v.erd; e.err = v.eerr; e.sl = v.esl; e.lat = v.elat;
    sbq.push_back(e);
    s0 = v.io ? 3 * TD : 2 * TD;
    {s_mr, s_io, s_rd, s_wr, s_m1, s_sl} = 6'b0;
    done = 1'b0; lat = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_io = v.io; cmd_m1 = v.m1;
    cmd_addr = v.a; cmd_wdata = v.wd; cdin = v.cdin; busreq = v.br;
    wait_n = (v.nw == 0);
    g = 0;
    while (cmd_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (cmd_ready !== 1'b1) begin
      chk($sformatf("v%0d_accept_timeout", idx), 32'(cmd_ready), 32'd1);
      void'(sbq.pop_back());
      cmd_valid = 1'b0;
      return;
    end
    for (int unsigned k = 1; k <= BUDGET && !done; k++) begin
      @(negedge clk);
      if (!merq_n)  s_mr = 1'b1;
      if (!iorq_n)  s_io = 1'b1;
      if (!rd_n)    s_rd = 1'b1;
      if (!wr_n)    s_wr = 1'b1;
      if (!m1_n)    s_m1 = 1'b1;
      if (!sltsl_n) s_sl = 1'b1;
      if (k == 1) begin
        chk($sformatf("v%0d_t1_addr", idx), 32'(addr), 32'(v.a));
        chk($sformatf("v%0d_t1_strobes", idx), 32'({merq_n, iorq_n, rd_n, wr_n, sltsl_n}), 32'h1F);
        chk($sformatf("v%0d_t1_m1n", idx), 32'(m1_n), 32'(!v.m1));
        if (v.wr) chk($sformatf("v%0d_t1_cdout", idx), 32'(cdout), 32'(v.wd));
        // A second, different request must be ignored while busy
        cmd_addr = ~v.a; cmd_wdata = ~v.wd; cmd_io = ~v.io;
      end
      if (k == TD + 1) begin
        chk($sformatf("v%0d_t2_strobes", idx),
            32'({v.io ? iorq_n : merq_n, v.wr ? wr_n : rd_n}), 32'd0);
        chk($sformatf("v%0d_t2_addr", idx), 32'(addr), 32'(v.a));
      end
      if (rsp_valid) begin
        done = 1'b1; lat = k;
        cmd_valid = 1'b0;
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
          chk($sformatf("v%0d_rdata", idx), 32'(rsp_rdata), 32'(e.rd));
          chk($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(e.err));
          chk($sformatf("v%0d_sltsl_seen", idx), 32'(s_sl), 32'(e.sl));
        end
        chk($sformatf("v%0d_done_strobes", idx),
            32'({merq_n, iorq_n, rd_n, wr_n, m1_n, sltsl_n}), 32'h3F);
        chk($sformatf("v%0d_kind_seen", idx), 32'({s_mr, s_io, s_rd, s_wr, s_m1}),
            32'({!v.io, v.io, !v.wr, v.wr, v.m1}));
        if (v.wr) chk($sformatf("v%0d_done_cdout", idx), 32'(cdout), 32'(v.wd));
      end
      if (v.nw == 0) wait_n = 1'b1;
      else           wait_n = (k > s0 + (v.nw - 1) * TD);
    end
    if (!done) begin
      chk($sformatf("v%0d_rsp_timeout", idx), 32'd0, 32'd1);
      if (sbq.size() != 0) void'(sbq.pop_front());
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_valid_pulse", idx), 32'({rsp_valid, cmd_ready}), 32'b01);
    chk($sformatf("v%0d_slot_reg", idx), 32'(slot_reg), 32'(v.eslot));
    wait_n = 1'b1;
  endtask

  initial begin
    int rv;
    vt[0]  = '{1'b1, 1'b1, 1'b0, 16'h00A8, 8'h04, 8'h00, 1'b0, 0,      8'hFF, 1'b0, 1'b0, 4*TD+1,      8'h04};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1, 0,      8'h5A, 1'b0, 1'b1, 3*TD+1,      8'h04};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 16'h5000, 8'h03, 8'h00, 1'b0, 0,      8'h5A, 1'b0, 1'b1, 3*TD+1,      8'h04};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 16'h00A8, 8'h50, 8'h00, 1'b0, 0,      8'h5A, 1'b0, 1'b0, 4*TD+1,      8'h50};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 8'h11, 1'b1, 0,      8'h11, 1'b0, 1'b1, 3*TD+1,      8'h50};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 16'h0123, 8'h00, 8'h77, 1'b0, 0,      8'hFF, 1'b0, 1'b0, 3*TD+1,      8'h50};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 16'h008E, 8'h00, 8'h3C, 1'b1, 0,      8'h3C, 1'b0, 1'b0, 4*TD+1,      8'h50};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 16'hC000, 8'h00, 8'h99, 1'b1, 3,      8'h99, 1'b0, 1'b1, 6*TD+1,      8'h50};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b1, 2,      8'hA5, 1'b0, 1'b0, 6*TD+1,      8'h50};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h12, 1'b1, WM + 5, 8'hFF, 1'b1, 1'b0, (WM+2)*TD+1, 8'h50};
    vt[10] = '{1'b1, 1'b0, 1'b0, 16'hC010, 8'hEE, 8'h00, 1'b0, 0,      8'hFF, 1'b0, 1'b1, 3*TD+1,      8'h50};
    vt[11] = '{1'b1, 1'b1, 1'b0, 16'h12A9, 8'hFF, 8'h00, 1'b0, 0,      8'hFF, 1'b0, 1'b0, 4*TD+1,      8'h50};
    vt[12] = '{1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 8'hC3, 1'b1, 0,      8'hC3, 1'b0, 1'b1, 3*TD+1,      8'h50};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_io = 1'b0; cmd_m1 = 1'b0;
    cmd_addr = 16'h0; cmd_wdata = 8'h0; cdin = 8'h0; busreq = 1'b0; wait_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({merq_n, iorq_n, rd_n, wr_n, m1_n, sltsl_n}), 32'h3F);
    chk("rst_addr_cdout", 32'({addr, cdout}), 32'h0);
    chk("rst_slot_reg", 32'(slot_reg), 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h0FF);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 13; i++) run(i, vt[i]);

    // Reset in the middle of a wait-extended memory read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_io = 1'b0; cmd_m1 = 1'b0;
    cmd_addr = 16'h8000; busreq = 1'b1; cdin = 8'h42; wait_n = 1'b0;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    rv = 0;
    for (int k = 1; k <= 2 * TD + 3; k++) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    chk("mid_rst_in_tw", 32'({merq_n, rd_n, sltsl_n}), 32'd0);
    #1 reset_n = 1'b0; cmd_valid = 1'b0;
    #1 chk("mid_rst_strobes", 32'({merq_n, iorq_n, rd_n, wr_n, m1_n, sltsl_n}), 32'h3F);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    reset_n = 1'b1; wait_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) rv++;
    chk("mid_rst_no_valid", 32'(rv), 32'd0);
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
    chk("mid_rst_slot_cleared", 32'(slot_reg), 32'h0);
    chk("mid_rst_sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
